// File: rtl/apb_fifo_buffer.sv
// apb_fifo_buffer
//   Single-clock show-ahead FIFO that buffers APB slave write data.
//   Storage is a DEPTH x DATA_W register array (not reset). The read and
//   write pointers carry one extra wrap bit so that full and empty can be
//   told apart and occupancy is a plain modular subtraction.
//
// Ports
//   PCLK        : clock, all logic on the rising edge
//   PRESET      : synchronous active-high reset (priority over all inputs)
//   write       : push strobe, ignored while full (raises err_write)
//   data_write  : push data, sampled when write=1
//   read        : pop strobe, ignored while empty (raises err_read)
//   data_read   : head-of-FIFO word, combinational from storage, 0 when empty
//   empty       : FIFO holds 0 entries
//   full        : FIFO holds DEPTH entries
//   almost_full : level >= AFULL_LVL
//   level       : current occupancy 0..DEPTH
//   err_write   : write attempted while full
//   err_read    : read attempted while empty
//   err_clr     : clears the sticky error flags (FIFO_ERR_STICKY_EN only)
//
// Configuration
//   FIFO_ERR_STICKY_EN defined     : error flags are sticky until err_clr;
//                                    a coincident error wins over err_clr.
//   FIFO_ERR_STICKY_EN not defined : error flags are one-cycle registered
//                                    pulses and err_clr is ignored.

module apb_fifo_buffer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_LVL = 6
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         write,
    input  logic [DATA_W-1:0]            data_write,
    input  logic                         read,
    output logic [DATA_W-1:0]            data_read,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         err_write,
    output logic                         err_read,
    input  logic                         err_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned PW    = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          err_write_q, err_write_d;
    logic          err_read_q,  err_read_d;

    logic          push;
    logic          pop;

    // Status derived only from registered pointers; no path from write/read.
    always_comb begin
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                      (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
        level       = wr_ptr_q - rd_ptr_q;
        almost_full = (level >= PW'(AFULL_LVL));
        data_read   = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_comb begin
        push     = write && !full;
        pop      = read && !empty;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
`ifdef FIFO_ERR_STICKY_EN
        err_write_d = (write && full)  || (err_write_q && !err_clr);
        err_read_d  = (read  && empty) || (err_read_q  && !err_clr);
`else
        err_write_d = write && full;
        err_read_d  = read  && empty;
`endif
    end

`ifndef FIFO_ERR_STICKY_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_write_q <= 1'b0;
            err_read_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_write_q <= err_write_d;
            err_read_q  <= err_read_d;
        end
    end

    // Storage is not reset; contents become unreachable when pointers clear.
    always_ff @(posedge PCLK) begin
        if (push && !PRESET) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_write;
        end
    end

    assign err_write = err_write_q;
    assign err_read  = err_read_q;

endmodule

// File: tb/tb_apb_fifo_buffer.sv
module tb_apb_fifo_buffer;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned AFULL_LVL = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic [DATA_W-1:0] rdata;
    logic              empty, full, afull;
    logic [3:0]        level;
    logic              err_w, err_r;
    logic              clr;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    apb_fifo_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
        .PCLK(clk), .PRESET(rst), .write(wr), .data_write(wdata), .read(rd),
        .data_read(rdata), .empty(empty), .full(full), .almost_full(afull),
        .level(level), .err_write(err_w), .err_read(err_r), .err_clr(clr)
    );

    // Reference model: a queue of words plus the two error flags.
    logic [DATA_W-1:0] q [$];
    logic              m_ew = 1'b0;
    logic              m_er = 1'b0;

    // {empty, full, almost_full, level, err_write, err_read, data_read}
    logic [40:0] dut_vec;
    assign dut_vec = {empty, full, afull, level, err_w, err_r, rdata};

    function automatic logic [40:0] model_vec();
        int unsigned n;
        logic [DATA_W-1:0] head;
        n    = q.size();
        head = (n == 0) ? '0 : q[0];
        return {n == 0, n == DEPTH, n >= AFULL_LVL, 4'(n), m_ew, m_er, head};
    endfunction

    // Apply one clock of stimulus to both DUT and model; returns #1 after edge.
    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r,
                        input logic c, input logic rs);
        bit was_full, was_empty;
        wr = w; wdata = d; rd = r; clr = c; rst = rs;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        @(posedge clk);
        #1;
        if (rs) begin
            q.delete();
            m_ew = 1'b0;
            m_er = 1'b0;
        end else begin
            if (r && !was_empty) void'(q.pop_front());
            if (w && !was_full)  q.push_back(d);
`ifdef FIFO_ERR_STICKY_EN
            m_ew = (w && was_full)  || (m_ew && !c);
            m_er = (r && was_empty) || (m_er && !c);
`else
            m_ew = w && was_full;
            m_er = r && was_empty;
`endif
        end
        wr = 1'b0; rd = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 32'h1234, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_run++;
        if (dut_vec !== 41'h100_0000_0000) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", dut_vec, 41'h100_0000_0000);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_run++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, DATA_W'(i * 32'h11), 1'b0, 1'b0, 1'b0);
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL fill[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        for (int i = 1; i <= 8; i++) begin
            n_run++;
            if (rdata !== DATA_W'(i * 32'h11)) begin
                n_fail++;
                $display("FAIL drain_head[%0d]: got %h expected %h", i, rdata, i * 32'h11);
            end
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL drain[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_full_write();
        for (int i = 0; i < 8; i++) step(1'b1, 32'h200 + i, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        n_run++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL full_write: got %h expected %h", dut_vec, model_vec());
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0);
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL full_write_hold[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        // Error and err_clr coincide, then a plain clear.
        step(1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b0);
        n_run++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL full_write_clr_race: got %h expected %h", dut_vec, model_vec());
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_run++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL full_write_clr: got %h expected %h", dut_vec, model_vec());
        end
        // Read+write while full: pop happens, push rejected.
        step(1'b1, 32'hCAFE, 1'b1, 1'b0, 1'b0);
        n_run++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL full_rw: got %h expected %h", dut_vec, model_vec());
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_empty_rw();
        step(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
        n_run++;
        if (dut_vec !== model_vec() || rdata !== 32'hA5 || level !== 4'd1) begin
            n_fail++;
            $display("FAIL empty_rw: got %h expected %h", dut_vec, model_vec());
        end
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        n_run++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL empty_rw_pop: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_wrap();
        for (int round = 0; round < 3; round++) begin
            for (int n = 0; n < 6; n++) step(1'b1, 32'h100 + round * 6 + n, 1'b0, 1'b0, 1'b0);
            for (int n = 0; n < 6; n++) begin
                n_run++;
                if (rdata !== DATA_W'(32'h100 + round * 6 + n)) begin
                    n_fail++;
                    $display("FAIL wrap[%0d][%0d]: got %h expected %h", round, n, rdata,
                             32'h100 + round * 6 + n);
                end
                step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            end
            n_run++;
            if (dut_vec !== model_vec() || level !== 4'd0) begin
                n_fail++;
                $display("FAIL wrap_level[%0d]: got %h expected %h", round, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), $urandom, 1'($urandom), $urandom_range(0, 7) == 0, 1'b0);
            n_run++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
            n_run++;
            if (dut_vec !== model_vec() || level !== 4'd4) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'h5555, 1'b1, 1'b1, 1'b1);
            n_run++;
            if (dut_vec !== 41'h100_0000_0000) begin
                n_fail++;
                $display("FAIL b2b_reset[%0d]: got %h expected %h", i, dut_vec, 41'h100_0000_0000);
            end
        end
    endtask

    initial begin
        wr = 1'b0; rd = 1'b0; clr = 1'b0; rst = 1'b1; wdata = '0;
        test_reset();
        test_fill_drain();
        test_full_write();
        test_empty_rw();
        test_wrap();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
